// File: rtl/cke_meter_pkg.sv
// Shared types and constants for the cke period meter and its lock detector.
package cke_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_LOST = 2'd3
  } meter_state_e;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  function automatic logic [7:0] err_inc(input logic [7:0] value);
    return (value == ERR_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/cke_lock_detect.sv
// Compares consecutive period measurements and declares lock once enough
// of them agree within tolerance; counts lock-loss events.
module cke_lock_detect
  import cke_meter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LOCK_CNT  = 4,
  parameter int TOLERANCE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas,
  input  logic [WIDTH-1:0] period,
  input  logic             restart,
  input  logic             loss,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CNT);
  localparam logic [WIDTH-1:0] TOL         = WIDTH'(TOLERANCE);

  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] diff;
  logic             prev_valid;
  logic [3:0]       match;
  logic [3:0]       match_inc;
  logic             hit;

  always_comb begin
    diff      = (period >= prev) ? (period - prev) : (prev - period);
    hit       = (diff <= TOL);
    match_inc = (match == LOCK_TARGET) ? match : match + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      match      <= '0;
      locked     <= 1'b0;
      err_cnt    <= '0;
    end else if (restart) begin
      prev_valid <= 1'b0;
      match      <= '0;
      locked     <= 1'b0;
    end else if (loss) begin
      // A loss invalidates the reference so the next period only reloads it.
      prev_valid <= 1'b0;
      match      <= '0;
      locked     <= 1'b0;
      if (locked) begin
        err_cnt <= err_inc(err_cnt);
      end
    end else if (meas) begin
      prev       <= period;
      prev_valid <= 1'b1;
      if (prev_valid) begin
        if (hit) begin
          match <= match_inc;
          if (match_inc == LOCK_TARGET) begin
            locked <= 1'b1;
          end
        end else begin
          match  <= '0;
          locked <= 1'b0;
          if (locked) begin
            err_cnt <= err_inc(err_cnt);
          end
        end
      end
    end
  end

endmodule

// File: rtl/cke_period_meter.sv
// Measures the spacing of single-cycle cke pulses in clk cycles, flags
// missing pulses with a programmable timeout and reports period lock.
//
// state   | meaning
// ST_IDLE | disabled; counter cleared, lock/timeout flags cleared
// ST_ARM  | enabled, waiting for the first pulse to start the counter
// ST_RUN  | counting between pulses, reporting each period
// ST_LOST | timeout expired; next pulse restarts measurement
module cke_period_meter
  import cke_meter_pkg::*;
#(
  parameter int CNT_WIDTH = 15,
  parameter int LOCK_CNT  = 4,
  parameter int TOLERANCE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cke,
  input  logic               enable,
  input  logic [CNT_WIDTH:0] timeout_limit,
  output logic [CNT_WIDTH:0] period,
  output logic               valid,
  output logic               locked,
  output logic               timeout,
  output logic [7:0]         err_cnt
);

  localparam logic [CNT_WIDTH:0] CNT_ONE = (CNT_WIDTH+1)'(1);

  meter_state_e       state;
  logic [CNT_WIDTH:0] cnt;
  logic [CNT_WIDTH:0] cnt_next;
  logic               meas;
  logic               restart;
  logic               loss;

  always_comb begin
    cnt_next = (&cnt) ? cnt : cnt + CNT_ONE;
    restart  = !enable || (state == ST_IDLE);
    meas     = enable && (state == ST_RUN) && cke;
    // A pulse landing on the timeout cycle counts as a pulse, not a loss.
    loss     = enable && (state == ST_RUN) && !cke &&
               (timeout_limit != '0) && (cnt == timeout_limit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        timeout <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt     <= '0;
            timeout <= 1'b0;
            state   <= ST_ARM;
          end
          ST_ARM: begin
            if (cke) begin
              cnt   <= CNT_ONE;
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (cke) begin
              period <= cnt;
              valid  <= 1'b1;
              cnt    <= CNT_ONE;
            end else begin
              cnt <= cnt_next;
              if (loss) begin
                timeout <= 1'b1;
                state   <= ST_LOST;
              end
            end
          end
          ST_LOST: begin
            if (cke) begin
              cnt     <= CNT_ONE;
              timeout <= 1'b0;
              state   <= ST_RUN;
            end else begin
              cnt <= cnt_next;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  cke_lock_detect #(
    .WIDTH     (CNT_WIDTH + 1),
    .LOCK_CNT  (LOCK_CNT),
    .TOLERANCE (TOLERANCE)
  ) u_lock (
    .clk     (clk),
    .rst     (rst),
    .meas    (meas),
    .period  (cnt),
    .restart (restart),
    .loss    (loss),
    .locked  (locked),
    .err_cnt (err_cnt)
  );

endmodule

// File: doc/cke_period_meter.md
Name: cke_period_meter

Overview:
Measures the interval, in system clock cycles, between successive single-cycle enable pulses. It is the receiving end of the clock-enable generator. It reports each measured period, flags loss of pulses via a programmable timeout, and declares lock once the period is stable. Typical uses are checking divider settings written through the register bus and supervising cke-driven peripherals (LCD timing, audio, PWM).

Parameters:
pCntWidth, 15, MSB index of counters; counter and period widths are pCntWidth+1 bits
pLockCnt, 4, consecutive matching comparisons required to assert oLocked (1..15)
pTolerance, 0, maximum absolute difference, in cycles, between consecutive periods that still counts as a match

Ports:
iSysClk  in  1  system clock; all logic on rising edge
iSysRst  in  1  asynchronous, active-high reset
iCke  in  1  pulse under measurement; synchronous to iSysClk, one cycle high per event
iEnable  in  1  measurement enable; low forces ST_IDLE
iTimeout  in  pCntWidth+1  cycles without a pulse before loss is declared; 0 disables the timeout
oPeriod  out  pCntWidth+1  last measured period in cycles
oValid  out  1  one-cycle strobe when oPeriod updates
oLocked  out  1  period stable
oTimeout  out  1  level; pulses lost
oErrCnt  out  8  lock-loss event count, saturating at 255

Behaviour:
- Reset (async) values: all outputs 0; rCnt=0; rMatch=0; rPrev=0; state ST_IDLE.
- All outputs are registered. A pulse on iCke in cycle t is reflected on the outputs from cycle t+1 (latency 1).
- States: ST_IDLE, ST_ARM, ST_RUN, ST_LOST.
- ST_IDLE:
  - rCnt=0; oValid=0, oLocked=0, oTimeout=0, rMatch=0; oPeriod and oErrCnt hold.
  - iEnable=1 -> ST_ARM.
- ST_ARM (waits for the first pulse):
  - iCke -> rCnt<=1, go to ST_RUN. No oValid is issued.
- ST_RUN:
  - rCnt increments each cycle and saturates at all-ones.
  - On iCke: oPeriod<=rCnt, oValid<=1, rCnt<=1.
  - Pulses P cycles apart give oPeriod=P, so a generator with divide value N yields oPeriod=N+1.
  - If iTimeout!=0, there is no pulse this cycle, and rCnt==iTimeout: go to ST_LOST, oTimeout<=1, oLocked<=0, rMatch<=0.
  - If the design was locked at that point, oErrCnt increments.
- ST_LOST:
  - rCnt keeps counting and saturating.
  - iCke -> rCnt<=1, oTimeout<=0, go to ST_RUN. No oValid is issued, because the interval is invalid.
  - The first pulse after loss starts a fresh measurement. rPrev is invalidated, so the next measurement only stores and does not compare.
- Lock detection, evaluated on each oValid measurement:
  - The first measurement after ST_ARM or ST_LOST only loads rPrev.
  - Later measurements compare |rCnt-rPrev|<=pTolerance, using unsigned subtraction of the larger minus the smaller.
  - Match: rMatch++ (saturating at pLockCnt); oLocked<=1 when the new rMatch==pLockCnt.
  - Mismatch: rMatch<=0, oLocked<=0; oErrCnt++ if oLocked was 1.
  - rPrev<=rCnt on every measurement.
  - oLocked changes on the same edge as the corresponding oValid.
- Saturated period: a pulse arriving with rCnt all-ones reports oPeriod=all-ones, treated as a normal measurement.
- Simultaneous events:
  - Pulse and timeout in the same cycle: the pulse wins and no timeout is raised.
  - iEnable falling in the same cycle as a pulse: the disable wins and no oValid is issued.
- iTimeout is sampled live; changing it mid-run takes effect on the next compare.
- Reset mid-operation: immediate return to reset values, including oErrCnt and oPeriod.

Decomposition:
- Shared package cke_meter_pkg holds:
  - state enum (ST_IDLE, ST_ARM, ST_RUN, ST_LOST), 2-bit encoding;
  - constant lpErrMax=8'hFF.
- Period widths derive from pCntWidth and stay local.
- One natural sub-module, cke_lock_detect, contains rPrev, the tolerance compare, rMatch, oLocked and oErrCnt.
  - Inputs: measurement strobe, period, restart, loss.
  - The top keeps the FSM, counter and timeout logic.

Test Plan:
1. iEnable=1, pulses every 100 cycles, pTolerance=0 -> first pulse gives no oValid; each subsequent pulse gives oValid with oPeriod=100; oLocked rises with the 5th oValid (4 matches).
2. Locked at 100, then one interval of 101 with pTolerance=0 -> oLocked falls on that oValid, oErrCnt=1; relock after 4 more matching intervals. Repeat with pTolerance=1 -> lock is held and oErrCnt stays 0.
3. iTimeout=250, pulses stop after lock -> oTimeout=1 and oLocked=0 exactly 250 cycles after the last pulse, oErrCnt increments. Resuming pulses -> oTimeout clears on the first pulse with no oValid; oValid appears on the second pulse.
4. Pulse arrives exactly when rCnt==iTimeout -> no timeout, oValid with oPeriod=iTimeout. iTimeout=0 with pulses 70000 cycles apart -> oPeriod=16'hFFFF and no timeout.
5. iEnable dropped mid-run, then raised -> oLocked=0, oValid=0, oPeriod holds; on re-enable the first pulse arms with no oValid.
6. Async iSysRst asserted mid-count, off the clock edge -> all outputs 0 immediately. After release, normal measurement of a 10-cycle period gives oPeriod=10.
